irq_dispatch_seq: RTL and testbench
===================================

IRQ_DISPATCH_SEQ -- requirements
Module: irq_dispatch_seq

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset (polarity and synchronicity fixed). Ports: CLK, nRES.
REQ-002 SHALL have port `CLK  in  1`: core clock; all state changes on the rising edge.
REQ-003 SHALL have port `nRES  in  1`: asynchronous active-low reset.
REQ-004 SHALL have port `MC_STB  in  1`: one-CLK pulse marking an M-cycle boundary.
REQ-005 SHALL have port `INSN_END  in  1`: instruction boundary; only sampled when MC_STB=1.
REQ-006 SHALL have port `IE  in  8`: interrupt enable register value.
REQ-007 SHALL have port `IF  in  8`: interrupt flag register value.
REQ-008 SHALL have ports `OP_EI, OP_DI, OP_RETI, OP_HALT  in  1 each`: decoded opcode strobes; only sampled when MC_STB=1.
REQ-009 SHALL have port `IRQ_ACK  out  8`: one-hot, one-CLK pulse that clears the serviced IF bit.
REQ-010 SHALL have port `VEC  out  8`: low byte of the dispatch target.
REQ-011 SHALL have port `PHASE  out  3`: current state encoding.
REQ-012 SHALL have ports `IME, HALTED, DISPATCH  out  1 each`: master enable, halt state, dispatch busy.
REQ-013 SHALL have ports `PUSH_HI, PUSH_LO, JUMP  out  1 each`: asserted for the whole of the corresponding state.

Function
REQ-014 SHALL define pending as P = IE & IF, 8 bits; priority goes to the lowest set index.
REQ-015 SHALL use states IDLE, HALT, W1, W2, PUSH_HI, PUSH_LO, JUMP; transitions occur only on MC_STB=1.
REQ-016 SHALL go IDLE->W1 on MC_STB & INSN_END & IME & (P!=0); in the same clock, IME and ime_pend are set to 0.
REQ-017 SHALL sequence W1->W2->PUSH_HI->PUSH_LO->JUMP->IDLE, one M-cycle each, so dispatch is exactly 5 M-cycles.
REQ-018 SHALL re-sample P on the MC_STB that leaves PUSH_HI:
- if P!=0: latch idx = lowest set bit; VEC = 0x40 + 8*idx; IRQ_ACK[idx] pulses in that same CLK.
- if P=0: VEC = 0x00 and IRQ_ACK stays 0 (models IE overwritten by the high-byte push).
REQ-019 SHALL hold VEC stable from PUSH_LO through JUMP, and hold it at 0x00 outside those states.
REQ-020 SHALL assert DISPATCH in W1..JUMP inclusive.
REQ-021 EI delay:
- OP_EI sets ime_pend.
- At the next INSN_END, IME <= ime_pend and ime_pend <= 0.
- The dispatch decision at that INSN_END uses the old IME, so exactly one instruction runs after EI.
REQ-022 SHALL have OP_DI clear IME and ime_pend immediately.
REQ-023 SHALL give OP_DI priority when OP_DI and OP_EI are asserted together.
REQ-024 SHALL have OP_RETI set IME immediately, without delay.
REQ-025 HALT entry: OP_HALT in IDLE with P=0 SHALL go to HALT; HALTED=1.
REQ-026 HALT exit: in HALT, P!=0 at MC_STB SHALL exit HALT:
- with IME=1, go to W1 (REQ-016 actions);
- with IME=0, go to IDLE without dispatch.
REQ-027 SHALL ignore OP_HALT with P!=0, except as specified in REQ-032.
REQ-028 SHALL ignore opcode strobes while DISPATCH=1 or HALTED=1.
REQ-029 SHALL ignore all inputs while MC_STB=0.

Reset
REQ-030 While nRES=0, SHALL asynchronously force:
- state to IDLE;
- IME, ime_pend and the latched idx to 0;
- VEC=0x00, IRQ_ACK=0x00, PHASE=IDLE;
- all single-bit outputs to 0.
REQ-031 SHALL abort a dispatch or HALT in progress when reset is asserted; no IRQ_ACK is generated afterwards.

Configuration
REQ-032 Macro IRQ_HALT_BUG_EN:
- When defined: adds output `HALT_BUG  out  1`. OP_HALT with IME=0 and P!=0 pulses HALT_BUG for one CLK and stays in IDLE.
- When undefined: the port is absent and the same case stays in IDLE silently.

Structure
REQ-033 Package irq_seq_pkg SHALL hold:
- the state enum and the PHASE encoding (IDLE=0 .. JUMP=6);
- VEC_BASE=8'h40;
- VEC_STEP=8.
REQ-034 Sub-module irq_prio_enc SHALL be purely combinational:
- inputs: P[7:0];
- outputs: any, idx[2:0], onehot[7:0].
REQ-035 Everything else SHALL reside in irq_dispatch_seq.

Verification
REQ-036 Test: IME=1, IE=0x05, IF=0x05, INSN_END.
- Expect W1 on the next MC_STB.
- After PUSH_HI: IRQ_ACK=0x01 and VEC=0x40.
- IDLE is reached after 5 MC_STB.
REQ-037 Test: set IE=0x00 during PUSH_HI.
- Expect VEC=0x00, IRQ_ACK never pulses, and JUMP still occurs.
REQ-038 Test: OP_EI at instruction N with P=0x04 pending.
- No dispatch at the end of N+1's predecessor boundary.
- Dispatch at the INSN_END after the next instruction: VEC=0x50, IRQ_ACK=0x04.
REQ-039 Test: OP_HALT with IME=0, P=0; then IF=0x10.
- HALTED drops on the next MC_STB.
- Returns to IDLE, DISPATCH stays 0, IRQ_ACK=0.
REQ-040 Test: OP_EI and OP_DI asserted together, then INSN_END with P!=0.
- Expect IME=0 and no dispatch.
REQ-041 Test: nRES low during PUSH_LO.
- Outputs reach their reset values immediately without waiting for CLK.
- After release: IDLE, IME=0, and no IRQ_ACK.

Source files
------------

// File: rtl/irq_seq_pkg.sv
// Shared types and constants for the interrupt dispatch sequencer.
// The enum values double as the externally visible PHASE encoding.
package irq_seq_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StHalt   = 3'd1,
    StW1     = 3'd2,
    StW2     = 3'd3,
    StPushHi = 3'd4,
    StPushLo = 3'd5,
    StJump   = 3'd6
  } irq_state_e;

  localparam logic [7:0]  VEC_BASE = 8'h40;
  localparam int unsigned VEC_STEP = 8;

  function automatic logic [7:0] vec_of(input logic [2:0] idx);
    return VEC_BASE + (8'(VEC_STEP) * {5'd0, idx});
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder for the pending vector.
module irq_prio_enc (
  input  logic [7:0] P,
  output logic       any,
  output logic [2:0] idx,
  output logic [7:0] onehot
);

  always_comb begin
    any    = |P;
    idx    = 3'd0;
    onehot = 8'h00;
    // Descending scan so the lowest set bit is the last one written.
    for (int i = 7; i >= 0; i--) begin
      if (P[i]) begin
        idx       = 3'(i);
        onehot    = 8'h00;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_dispatch_seq.sv
// Interrupt dispatch sequencer: IME/EI-delay handling, HALT and the 5 M-cycle dispatch.
// Optional HALT_BUG output is built when IRQ_HALT_BUG_EN is defined.
module irq_dispatch_seq
  import irq_seq_pkg::*;
(
  input  logic       CLK,
  input  logic       nRES,
  input  logic       MC_STB,
  input  logic       INSN_END,
  input  logic [7:0] IE,
  input  logic [7:0] IF,
  input  logic       OP_EI,
  input  logic       OP_DI,
  input  logic       OP_RETI,
  input  logic       OP_HALT,
  output logic [7:0] IRQ_ACK,
  output logic [7:0] VEC,
  output logic [2:0] PHASE,
  output logic       IME,
  output logic       HALTED,
  output logic       DISPATCH,
  output logic       PUSH_HI,
  output logic       PUSH_LO,
`ifdef IRQ_HALT_BUG_EN
  output logic       JUMP,
  output logic       HALT_BUG
`else
  output logic       JUMP
`endif
);

  logic [7:0] p;
  logic       p_any;
  logic [2:0] p_idx;
  logic [7:0] p_onehot;

  assign p = IE & IF;

  irq_prio_enc u_prio (
    .P      (p),
    .any    (p_any),
    .idx    (p_idx),
    .onehot (p_onehot)
  );

  irq_state_e state_q, state_d;
  logic       ime_q, ime_d;
  logic       pend_q, pend_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] vec_q, vec_d;
  logic [7:0] ack_q, ack_d;
  logic       halted_q, dispatch_q, push_hi_q, push_lo_q, jump_q;
`ifdef IRQ_HALT_BUG_EN
  logic       hbug_q, hbug_d;
`endif

  always_comb begin
    state_d = state_q;
    ime_d   = ime_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    ack_d   = 8'h00;
`ifdef IRQ_HALT_BUG_EN
    hbug_d  = 1'b0;
`endif
    if (MC_STB) begin
      unique case (state_q)
        StIdle: begin
          // Dispatch decision uses the IME value from before this boundary.
          if (INSN_END && ime_q && p_any) begin
            state_d = StW1;
            ime_d   = 1'b0;
            pend_d  = 1'b0;
          end else begin
            if (INSN_END && pend_q) begin
              ime_d  = 1'b1;
              pend_d = 1'b0;
            end
            if (OP_DI) begin
              ime_d  = 1'b0;
              pend_d = 1'b0;
            end else begin
              if (OP_EI)   pend_d = 1'b1;
              if (OP_RETI) ime_d  = 1'b1;
            end
            if (OP_HALT) begin
              if (!p_any) begin
                state_d = StHalt;
              end
`ifdef IRQ_HALT_BUG_EN
              else if (!ime_q) begin
                hbug_d = 1'b1;
              end
`endif
            end
          end
        end
        StHalt: begin
          if (p_any) begin
            if (ime_q) begin
              state_d = StW1;
              ime_d   = 1'b0;
              pend_d  = 1'b0;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StW1:     state_d = StW2;
        StW2:     state_d = StPushHi;
        StPushHi: begin
          // Pending set is re-sampled here; it may have vanished during the high push.
          state_d = StPushLo;
          if (p_any) begin
            idx_d = p_idx;
            vec_d = vec_of(p_idx);
            ack_d = p_onehot;
          end else begin
            vec_d = 8'h00;
          end
        end
        StPushLo: state_d = StJump;
        StJump: begin
          state_d = StIdle;
          vec_d   = 8'h00;
        end
        default: begin
          state_d = StIdle;
          vec_d   = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      state_q    <= StIdle;
      ime_q      <= 1'b0;
      pend_q     <= 1'b0;
      idx_q      <= 3'd0;
      vec_q      <= 8'h00;
      ack_q      <= 8'h00;
      halted_q   <= 1'b0;
      dispatch_q <= 1'b0;
      push_hi_q  <= 1'b0;
      push_lo_q  <= 1'b0;
      jump_q     <= 1'b0;
`ifdef IRQ_HALT_BUG_EN
      hbug_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ime_q      <= ime_d;
      pend_q     <= pend_d;
      idx_q      <= idx_d;
      vec_q      <= vec_d;
      ack_q      <= ack_d;
      halted_q   <= (state_d == StHalt);
      dispatch_q <= (state_d == StW1) || (state_d == StW2) || (state_d == StPushHi) ||
                    (state_d == StPushLo) || (state_d == StJump);
      push_hi_q  <= (state_d == StPushHi);
      push_lo_q  <= (state_d == StPushLo);
      jump_q     <= (state_d == StJump);
`ifdef IRQ_HALT_BUG_EN
      hbug_q     <= hbug_d;
`endif
    end
  end

  assign PHASE    = state_q;
  assign IME      = ime_q;
  assign VEC      = vec_q;
  assign IRQ_ACK  = ack_q;
  assign HALTED   = halted_q;
  assign DISPATCH = dispatch_q;
  assign PUSH_HI  = push_hi_q;
  assign PUSH_LO  = push_lo_q;
  assign JUMP     = jump_q;
`ifdef IRQ_HALT_BUG_EN
  assign HALT_BUG = hbug_q;
`endif

endmodule

// File: tb/tb_irq_dispatch_seq.sv
// Bench for irq_dispatch_seq: directed scenarios plus a randomized run against a step-level model.
module tb_irq_dispatch_seq;

  logic       CLK = 1'b0;
  logic       nRES = 1'b1;
  logic       MC_STB = 1'b0;
  logic       INSN_END = 1'b0;
  logic [7:0] IE = 8'h00;
  logic [7:0] IF = 8'h00;
  logic       OP_EI = 1'b0, OP_DI = 1'b0, OP_RETI = 1'b0, OP_HALT = 1'b0;
  logic [7:0] IRQ_ACK, VEC;
  logic [2:0] PHASE;
  logic       IME, HALTED, DISPATCH, PUSH_HI, PUSH_LO, JUMP;
`ifdef IRQ_HALT_BUG_EN
  logic       HALT_BUG;
`endif

  irq_dispatch_seq dut (
    .CLK      (CLK),
    .nRES     (nRES),
    .MC_STB   (MC_STB),
    .INSN_END (INSN_END),
    .IE       (IE),
    .IF       (IF),
    .OP_EI    (OP_EI),
    .OP_DI    (OP_DI),
    .OP_RETI  (OP_RETI),
    .OP_HALT  (OP_HALT),
    .IRQ_ACK  (IRQ_ACK),
    .VEC      (VEC),
    .PHASE    (PHASE),
    .IME      (IME),
    .HALTED   (HALTED),
    .DISPATCH (DISPATCH),
    .PUSH_HI  (PUSH_HI),
    .PUSH_LO  (PUSH_LO),
`ifdef IRQ_HALT_BUG_EN
    .JUMP     (JUMP),
    .HALT_BUG (HALT_BUG)
`else
    .JUMP     (JUMP)
`endif
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Model: m_step counts M-cycles into a dispatch (0 = none, 1..5 = W1..JUMP).
  int         m_step;
  bit         m_halted, m_ime, m_pend, m_hbug;
  logic [7:0] m_vec, m_ack;

  task automatic model_reset();
    m_step = 0; m_halted = 0; m_ime = 0; m_pend = 0; m_hbug = 0;
    m_vec = 8'h00; m_ack = 8'h00;
  endtask

  task automatic model_strobe(input bit e, input bit ei, input bit di, input bit reti,
                              input bit halt);
    logic [7:0] p;
    bit         old_ime;
    int         low;
    p = IE & IF;
    old_ime = m_ime;
    m_ack = 8'h00;
    m_hbug = 0;
    low = -1;
    for (int i = 7; i >= 0; i--) if (p[i]) low = i;
    if (m_step != 0) begin
      if (m_step == 3) begin
        if (low >= 0) begin
          m_vec = 8'h40 + 8'(8 * low);
          m_ack = 8'(1 << low);
        end else begin
          m_vec = 8'h00;
        end
      end
      m_step = (m_step == 5) ? 0 : m_step + 1;
      if (m_step == 0) m_vec = 8'h00;
    end else if (m_halted) begin
      if (p != 0) begin
        m_halted = 0;
        if (m_ime) begin m_step = 1; m_ime = 0; m_pend = 0; end
      end
    end else if (e && m_ime && p != 0) begin
      m_step = 1; m_ime = 0; m_pend = 0;
    end else begin
      if (e && m_pend) begin m_ime = 1; m_pend = 0; end
      if (di) begin
        m_ime = 0; m_pend = 0;
      end else begin
        if (ei) m_pend = 1;
        if (reti) m_ime = 1;
      end
      if (halt) begin
        if (p == 0) m_halted = 1;
        else if (!old_ime) m_hbug = 1;
      end
    end
  endtask

  function automatic logic [24:0] exp_bus();
    logic [2:0] ph;
    ph = m_halted ? 3'd1 : ((m_step == 0) ? 3'd0 : 3'(m_step + 1));
    return {ph, m_ime, m_halted, (m_step != 0), (m_step == 3), (m_step == 4), (m_step == 5),
            m_vec, m_ack};
  endfunction

  function automatic logic [24:0] obs_bus();
    return {PHASE, IME, HALTED, DISPATCH, PUSH_HI, PUSH_LO, JUMP, VEC, IRQ_ACK};
  endfunction

  // One MC_STB pulse; returns just after the capturing edge.
  task automatic strobe(input bit e, input bit ei, input bit di, input bit reti, input bit halt);
    @(negedge CLK);
    MC_STB = 1; INSN_END = e; OP_EI = ei; OP_DI = di; OP_RETI = reti; OP_HALT = halt;
    model_strobe(e, ei, di, reti, halt);
    @(negedge CLK);
    MC_STB = 0; INSN_END = 0; OP_EI = 0; OP_DI = 0; OP_RETI = 0; OP_HALT = 0;
  endtask

  // Idle clocks with junk on the strobe-qualified inputs; nothing may change.
  task automatic gap();
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      INSN_END = 1'($urandom); OP_EI = 1'($urandom); OP_DI = 1'($urandom);
      OP_RETI = 1'($urandom); OP_HALT = 1'($urandom);
    end
    m_ack = 8'h00;
    m_hbug = 0;
  endtask

  task automatic test_reset();
    #2 nRES = 0;
    #1;
    model_reset();
    vectors++;
    if (obs_bus() !== 25'h0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want %h", obs_bus(), 25'h0);
    end
    repeat (3) @(negedge CLK);
    nRES = 1;
  endtask

  task automatic test_basic_dispatch();
    IE = 8'h05; IF = 8'h05;
    strobe(0, 0, 0, 1, 0); gap();
    vectors++;
    if (obs_bus() !== exp_bus()) begin
      miscompares++; $display("FAIL basic_reti: got %h want %h", obs_bus(), exp_bus());
    end
    strobe(1, 0, 0, 0, 0);
    vectors++;
    if (PHASE !== 3'd2 || DISPATCH !== 1'b1 || IME !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_w1: got phase=%0d disp=%b ime=%b want 2 1 0", PHASE, DISPATCH, IME);
    end
    gap();
    for (int k = 1; k <= 5; k++) begin
      strobe(0, 0, 0, 0, 0);
      vectors++;
      if (obs_bus() !== exp_bus()) begin
        miscompares++; $display("FAIL basic_step%0d: got %h want %h", k, obs_bus(), exp_bus());
      end
      if (k == 3) begin
        vectors++;
        if ({IRQ_ACK, VEC} !== 16'h0140) begin
          miscompares++;
          $display("FAIL basic_ack_vec: got ack=%h vec=%h want 01 40", IRQ_ACK, VEC);
        end
        IF = IF & ~8'h01;
      end
      gap();
    end
    vectors++;
    if (PHASE !== 3'd0 || DISPATCH !== 1'b0 || VEC !== 8'h00) begin
      miscompares++;
      $display("FAIL basic_idle: got phase=%0d disp=%b vec=%h want 0 0 00", PHASE, DISPATCH, VEC);
    end
    IF = 8'h00;
  endtask

  task automatic test_ie_overwrite();
    IE = 8'h02; IF = 8'h02;
    strobe(0, 0, 0, 1, 0); gap();
    strobe(1, 0, 0, 0, 0); gap();
    strobe(0, 0, 0, 0, 0); gap();
    strobe(0, 0, 0, 0, 0);
    IE = 8'h00;
    gap();
    strobe(0, 0, 0, 0, 0);
    vectors++;
    if (PHASE !== 3'd5 || VEC !== 8'h00 || IRQ_ACK !== 8'h00) begin
      miscompares++;
      $display("FAIL ovr_pushlo: got phase=%0d vec=%h ack=%h want 5 00 00", PHASE, VEC, IRQ_ACK);
    end
    gap();
    strobe(0, 0, 0, 0, 0);
    vectors++;
    if (PHASE !== 3'd6 || JUMP !== 1'b1 || IRQ_ACK !== 8'h00) begin
      miscompares++;
      $display("FAIL ovr_jump: got phase=%0d jump=%b ack=%h want 6 1 00", PHASE, JUMP, IRQ_ACK);
    end
    gap();
    strobe(0, 0, 0, 0, 0); gap();
    vectors++;
    if (obs_bus() !== exp_bus()) begin
      miscompares++; $display("FAIL ovr_idle: got %h want %h", obs_bus(), exp_bus());
    end
    IE = 8'h00; IF = 8'h00;
  endtask

  task automatic test_ei_delay();
    IE = 8'h04; IF = 8'h04;
    strobe(0, 0, 1, 0, 0); gap();
    strobe(0, 1, 0, 0, 0); gap();
    strobe(1, 0, 0, 0, 0); gap();
    vectors++;
    if (PHASE !== 3'd0 || IME !== 1'b1) begin
      miscompares++;
      $display("FAIL ei_first_end: got phase=%0d ime=%b want 0 1", PHASE, IME);
    end
    strobe(0, 0, 0, 0, 0); gap();
    strobe(1, 0, 0, 0, 0);
    vectors++;
    if (PHASE !== 3'd2) begin
      miscompares++; $display("FAIL ei_dispatch: got phase=%0d want 2", PHASE);
    end
    gap();
    strobe(0, 0, 0, 0, 0); gap();
    strobe(0, 0, 0, 0, 0); gap();
    strobe(0, 0, 0, 0, 0);
    vectors++;
    if ({IRQ_ACK, VEC} !== 16'h0450) begin
      miscompares++;
      $display("FAIL ei_ack_vec: got ack=%h vec=%h want 04 50", IRQ_ACK, VEC);
    end
    IF = 8'h00;
    gap();
    strobe(0, 0, 0, 0, 0); gap();
    strobe(0, 0, 0, 0, 0); gap();
    vectors++;
    if (obs_bus() !== exp_bus()) begin
      miscompares++; $display("FAIL ei_idle: got %h want %h", obs_bus(), exp_bus());
    end
    IE = 8'h00;
  endtask

  task automatic test_halt();
    IE = 8'h10; IF = 8'h00;
    strobe(0, 0, 1, 0, 0); gap();
    strobe(0, 0, 0, 0, 1); gap();
    vectors++;
    if (PHASE !== 3'd1 || HALTED !== 1'b1) begin
      miscompares++; $display("FAIL halt_enter: got phase=%0d halted=%b want 1 1", PHASE, HALTED);
    end
    strobe(1, 1, 0, 1, 0); gap();
    vectors++;
    if (obs_bus() !== exp_bus()) begin
      miscompares++; $display("FAIL halt_ignore_ops: got %h want %h", obs_bus(), exp_bus());
    end
    IF = 8'h10;
    strobe(0, 0, 0, 0, 0);
    vectors++;
    if ({PHASE, HALTED, DISPATCH, IRQ_ACK} !== 13'h0) begin
      miscompares++;
      $display("FAIL halt_exit: got phase=%0d halted=%b disp=%b ack=%h want 0 0 0 00",
               PHASE, HALTED, DISPATCH, IRQ_ACK);
    end
    gap();
    strobe(1, 0, 0, 0, 0); gap();
    vectors++;
    if (obs_bus() !== exp_bus()) begin
      miscompares++; $display("FAIL halt_after: got %h want %h", obs_bus(), exp_bus());
    end
    IE = 8'h00; IF = 8'h00;
  endtask

  task automatic test_ei_di();
    strobe(0, 1, 1, 0, 0); gap();
    IE = 8'h01; IF = 8'h01;
    for (int k = 0; k < 2; k++) begin
      strobe(1, 0, 0, 0, 0); gap();
      vectors++;
      if (PHASE !== 3'd0 || IME !== 1'b0 || DISPATCH !== 1'b0) begin
        miscompares++;
        $display("FAIL ei_di_%0d: got phase=%0d ime=%b disp=%b want 0 0 0", k, PHASE, IME,
                 DISPATCH);
      end
    end
    IE = 8'h00; IF = 8'h00;
  endtask

  task automatic test_reset_mid();
    IE = 8'h08; IF = 8'h08;
    strobe(0, 0, 0, 1, 0); gap();
    strobe(1, 0, 0, 0, 0); gap();
    strobe(0, 0, 0, 0, 0); gap();
    strobe(0, 0, 0, 0, 0); gap();
    strobe(0, 0, 0, 0, 0);
    #2 nRES = 0;
    #1;
    model_reset();
    vectors++;
    if (obs_bus() !== 25'h0) begin
      miscompares++; $display("FAIL reset_async: got %h want %h", obs_bus(), 25'h0);
    end
    @(negedge CLK);
    nRES = 1;
    gap();
    strobe(0, 0, 0, 0, 0);
    vectors++;
    if (obs_bus() !== exp_bus() || PHASE !== 3'd0 || IME !== 1'b0 || IRQ_ACK !== 8'h00) begin
      miscompares++; $display("FAIL reset_after: got %h want %h", obs_bus(), exp_bus());
    end
    gap();
    IE = 8'h00; IF = 8'h00;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) IE = 8'($urandom);
      if ($urandom_range(0, 2) == 0) IF = 8'($urandom & $urandom & $urandom);
      strobe(1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
      vectors++;
      if (obs_bus() !== exp_bus()) begin
        miscompares++; $display("FAIL rand_%0d: got %h want %h", n, obs_bus(), exp_bus());
      end
`ifdef IRQ_HALT_BUG_EN
      vectors++;
      if (HALT_BUG !== m_hbug) begin
        miscompares++; $display("FAIL rand_hbug_%0d: got %b want %b", n, HALT_BUG, m_hbug);
      end
`endif
      if (m_ack != 8'h00) IF = IF & ~m_ack;
      gap();
      vectors++;
      if (obs_bus() !== exp_bus()) begin
        miscompares++; $display("FAIL rand_gap_%0d: got %h want %h", n, obs_bus(), exp_bus());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_dispatch();
    test_ie_overwrite();
    test_ei_delay();
    test_halt();
    test_ei_di();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
